// File: rtl/mips_multicycle_control_pkg.sv
// Shared constants for the multi-cycle MIPS control path: opcodes, functs,
// ALU_op codes, mux select codes, FSM state encodings and the control word.
package mips_multicycle_control_pkg;

  localparam int ST_W = 5;
  localparam int OP_W = 6;

  // Opcodes (IR[31:26])
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

  // Funct codes (IR[5:0]), shared with ALU_control
  localparam logic [OP_W-1:0] FN_JR  = 6'b001000;
  localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
  localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
  localparam logic [OP_W-1:0] FN_AND = 6'b100100;
  localparam logic [OP_W-1:0] FN_OR  = 6'b100101;
  localparam logic [OP_W-1:0] FN_SLT = 6'b101010;

  // ALU_op codes into ALU_control
  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_SUB    = 2'b01;
  localparam logic [1:0] ALUOP_DECODE = 2'b10;

  // Mux select codes
  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH  = 2'b11;
  localparam logic [1:0] REGDST_RT   = 2'b00;
  localparam logic [1:0] REGDST_RD   = 2'b01;
  localparam logic [1:0] REGDST_RA   = 2'b10;
  localparam logic [1:0] M2R_ALUOUT  = 2'b00;
  localparam logic [1:0] M2R_MDR     = 2'b01;
  localparam logic [1:0] M2R_PC      = 2'b10;
  localparam logic [1:0] PCSRC_ALU   = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP  = 2'b10;
  localparam logic [1:0] PCSRC_RS    = 2'b11;

  // FSM state encodings; 16..31 are unreachable
  localparam logic [ST_W-1:0] S_IDLE     = 5'd0;
  localparam logic [ST_W-1:0] S_FETCH    = 5'd1;
  localparam logic [ST_W-1:0] S_DECODE   = 5'd2;
  localparam logic [ST_W-1:0] S_MEMADR   = 5'd3;
  localparam logic [ST_W-1:0] S_MEMRD    = 5'd4;
  localparam logic [ST_W-1:0] S_MEMWB    = 5'd5;
  localparam logic [ST_W-1:0] S_MEMWR    = 5'd6;
  localparam logic [ST_W-1:0] S_RTYPE_EX = 5'd7;
  localparam logic [ST_W-1:0] S_RTYPE_WB = 5'd8;
  localparam logic [ST_W-1:0] S_ADDI_EX  = 5'd9;
  localparam logic [ST_W-1:0] S_LOGI_EX  = 5'd10;
  localparam logic [ST_W-1:0] S_ITYPE_WB = 5'd11;
  localparam logic [ST_W-1:0] S_BEQ      = 5'd12;
  localparam logic [ST_W-1:0] S_JUMP     = 5'd13;
  localparam logic [ST_W-1:0] S_JAL      = 5'd14;
  localparam logic [ST_W-1:0] S_JR       = 5'd15;

  // Datapath control word produced per state
  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_inst_sel;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control <-> datapath bundle. The controller is the master: it reads the
// instruction fields, ALU zero flag and memory ready, and drives the
// datapath enables, mux selects and ALU_control inputs.
// Memory handshake: MemRead/MemWrite are held asserted for the whole access;
// the access completes in the cycle the memory returns mem_ready=1, and
// mem_ready is ignored in any state that is not performing an access.
interface mips_multicycle_control_if;
  import mips_multicycle_control_pkg::*;

  logic [OP_W-1:0] opcode;
  logic [OP_W-1:0] funct;
  logic            zero;
  logic            mem_ready;

  logic [1:0]      ALU_op;
  logic            alu_inst_sel;
  logic            ALUSrcA;
  logic [1:0]      ALUSrcB;
  logic            IorD;
  logic            MemRead;
  logic            MemWrite;
  logic            IRWrite;
  logic            RegWrite;
  logic            PCWrite;
  logic            PCWriteCond;
  logic [1:0]      RegDst;
  logic [1:0]      MemtoReg;
  logic [1:0]      PCSource;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output ALU_op, alu_inst_sel, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite,
           IRWrite, RegWrite, PCWrite, PCWriteCond, RegDst, MemtoReg, PCSource
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  ALU_op, alu_inst_sel, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite,
           IRWrite, RegWrite, PCWrite, PCWriteCond, RegDst, MemtoReg, PCSource
  );

endinterface

// File: rtl/mips_multicycle_control_outdec.sv
// Combinational state -> control word decoder. Everything is Moore except
// the FETCH IR/PC write strobes, which fire only in the cycle memory is ready.
module mips_multicycle_control_outdec
  import mips_multicycle_control_pkg::*;
(
  input  logic [ST_W-1:0] state,
  input  logic            mem_ready,
  output ctrl_t           ctrl
);

  // Decode the control word; unlisted fields (and IDLE/unreachable states) stay 0
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMMSH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REGDST_RT;
        ctrl.mem_to_reg = M2R_MDR;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_RTYPE_EX: begin
        ctrl.alu_src_a    = 1'b1;
        ctrl.alu_src_b    = SRCB_RT;
        ctrl.alu_op       = ALUOP_DECODE;
        ctrl.alu_inst_sel = 1'b0;
      end
      S_RTYPE_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REGDST_RD;
        ctrl.mem_to_reg = M2R_ALUOUT;
      end
      S_LOGI_EX: begin
        ctrl.alu_src_a    = 1'b1;
        ctrl.alu_src_b    = SRCB_IMM;
        ctrl.alu_op       = ALUOP_DECODE;
        ctrl.alu_inst_sel = 1'b1;
      end
      S_ITYPE_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REGDST_RT;
        ctrl.mem_to_reg = M2R_ALUOUT;
      end
      S_BEQ: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_RT;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_JAL: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REGDST_RA;
        ctrl.mem_to_reg = M2R_PC;
      end
      S_JR: begin
        ctrl.alu_op       = ALUOP_DECODE;
        ctrl.alu_inst_sel = 1'b0;
        ctrl.pc_write     = 1'b1;
        ctrl.pc_source    = PCSRC_RS;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multi-cycle MIPS datapath. Holds the state register,
// next-state logic and the registered illegal-instruction pulse; the control
// word itself comes from the output decoder.
module mips_multicycle_control
  import mips_multicycle_control_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  mips_multicycle_control_if.master    bus,
  output logic                         illegal,
  output logic [ST_W-1:0]              state_dbg
);

  logic [ST_W-1:0] state_q, state_d;
  logic            illegal_q, illegal_d;
  ctrl_t           ctrl;

  // The zero flag gates PCWriteCond inside the datapath, not here
  logic unused_zero;
  assign unused_zero = bus.zero;

  // Next-state and illegal-pulse computation
  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:       state_d = (bus.funct == FN_JR) ? S_JR : S_RTYPE_EX;
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_BEQ:         state_d = S_BEQ;
          OP_J:           state_d = S_JUMP;
          OP_JAL:         state_d = S_JAL;
          OP_ADDI:        state_d = S_ADDI_EX;
          OP_ANDI, OP_ORI: state_d = S_LOGI_EX;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        if (bus.opcode == OP_LW) begin
          state_d = S_MEMRD;
        end else if (bus.opcode == OP_SW) begin
          state_d = S_MEMWR;
        end else begin
          // IR changed under us; abandon the instruction
          state_d   = S_FETCH;
          illegal_d = 1'b1;
        end
      end
      S_MEMRD:    if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWR:    if (bus.mem_ready) state_d = S_FETCH;
      S_RTYPE_EX: state_d = S_RTYPE_WB;
      S_ADDI_EX,
      S_LOGI_EX:  state_d = S_ITYPE_WB;
      S_MEMWB, S_RTYPE_WB, S_ITYPE_WB,
      S_BEQ, S_JUMP, S_JAL, S_JR: state_d = S_FETCH;
      default: begin
        state_d   = S_FETCH;
        illegal_d = 1'b1;
      end
    endcase
  end

  // State and illegal flops; reset aborts any instruction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  mips_multicycle_control_outdec u_outdec (
    .state     (state_q),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl)
  );

  assign bus.ALU_op       = ctrl.alu_op;
  assign bus.alu_inst_sel = ctrl.alu_inst_sel;
  assign bus.ALUSrcA      = ctrl.alu_src_a;
  assign bus.ALUSrcB      = ctrl.alu_src_b;
  assign bus.IorD         = ctrl.iord;
  assign bus.MemRead      = ctrl.mem_read;
  assign bus.MemWrite     = ctrl.mem_write;
  assign bus.IRWrite      = ctrl.ir_write;
  assign bus.RegWrite     = ctrl.reg_write;
  assign bus.PCWrite      = ctrl.pc_write;
  assign bus.PCWriteCond  = ctrl.pc_write_cond;
  assign bus.RegDst       = ctrl.reg_dst;
  assign bus.MemtoReg     = ctrl.mem_to_reg;
  assign bus.PCSource     = ctrl.pc_source;

  assign illegal   = illegal_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for the multi-cycle MIPS control FSM: cycle-by-cycle vector table of
// inputs and expected state/illegal, with the expected control word for each
// state written out from the instruction-step definitions.
module tb_mips_multicycle_control;
  import mips_multicycle_control_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  logic illegal;
  logic [4:0] state_dbg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mips_multicycle_control_if bus ();

  mips_multicycle_control dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .illegal   (illegal),
    .state_dbg (state_dbg)
  );

  // ---------------- vectors / scoreboard ----------------
  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic [5:0] fn;
    logic       zero;
    logic       mr;
    logic [4:0] st;
    logic       ill;
  } vec_t;

  typedef struct packed {
    logic [4:0] st;
    logic       ill;
    ctrl_t      c;
  } exp_t;

  localparam int EXP_W = $bits(exp_t);

  vec_t vecs[$];
  logic [EXP_W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  // Expected control word for a state, written from the step descriptions
  function automatic ctrl_t exp_ctrl(input logic [4:0] st, input logic mr);
    ctrl_t c;
    c = '0;
    case (st)
      5'd1:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_write = mr; end
      5'd2:  begin c.alu_src_b = 2'b11; end
      5'd3:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      5'd4:  begin c.mem_read = 1; c.iord = 1; end
      5'd5:  begin c.reg_write = 1; c.mem_to_reg = 2'b01; end
      5'd6:  begin c.mem_write = 1; c.iord = 1; end
      5'd7:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
      5'd8:  begin c.reg_write = 1; c.reg_dst = 2'b01; end
      5'd9:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      5'd10: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_op = 2'b10; c.alu_inst_sel = 1; end
      5'd11: begin c.reg_write = 1; end
      5'd12: begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1; c.pc_source = 2'b01; end
      5'd13: begin c.pc_write = 1; c.pc_source = 2'b10; end
      5'd14: begin c.pc_write = 1; c.pc_source = 2'b10; c.reg_write = 1; c.reg_dst = 2'b10; c.mem_to_reg = 2'b10; end
      5'd15: begin c.alu_op = 2'b10; c.pc_write = 1; c.pc_source = 2'b11; end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic ctrl_t dut_ctrl();
    ctrl_t c;
    c.alu_op        = bus.ALU_op;
    c.alu_inst_sel  = bus.alu_inst_sel;
    c.alu_src_a     = bus.ALUSrcA;
    c.alu_src_b     = bus.ALUSrcB;
    c.iord          = bus.IorD;
    c.mem_read      = bus.MemRead;
    c.mem_write     = bus.MemWrite;
    c.ir_write      = bus.IRWrite;
    c.reg_write     = bus.RegWrite;
    c.pc_write      = bus.PCWrite;
    c.pc_write_cond = bus.PCWriteCond;
    c.reg_dst       = bus.RegDst;
    c.mem_to_reg    = bus.MemtoReg;
    c.pc_source     = bus.PCSource;
    return c;
  endfunction

  task automatic add_v(input logic r, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic mr, input logic [4:0] st, input logic ill);
    vec_t v;
    v.rst = r; v.op = op; v.fn = fn; v.zero = z; v.mr = mr; v.st = st; v.ill = ill;
    vecs.push_back(v);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input vec_t v);
    exp_t e;
    @(posedge clk);
    #1;
    rst           = v.rst;
    bus.opcode    = v.op;
    bus.funct     = v.fn;
    bus.zero      = v.zero;
    bus.mem_ready = v.mr;
    e.st  = v.st;
    e.ill = v.ill;
    e.c   = exp_ctrl(v.st, v.mr);
    exp_q.push_back(e);
  endtask

  // ---------------- checker ----------------
  task automatic check(input int idx);
    exp_t e;
    ctrl_t got;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL vec%0d scoreboard: got empty queue, required an entry", idx);
    end else begin
      e = exp_t'(exp_q.pop_front());
      got = dut_ctrl();
      if (state_dbg !== e.st) begin
        n_err++;
        $display("FAIL vec%0d state: got %0d required %0d", idx, state_dbg, e.st);
      end
      if (illegal !== e.ill) begin
        n_err++;
        $display("FAIL vec%0d illegal: got %b required %b", idx, illegal, e.ill);
      end
      if (got !== e.c) begin
        n_err++;
        $display("FAIL vec%0d ctrl: got %b required %b (state %0d)", idx, got, e.c, e.st);
      end
      if ((bus.RegWrite & bus.MemWrite) !== 1'b0) begin
        n_err++;
        $display("FAIL vec%0d wr_excl: got RegWrite&MemWrite=%b required 0", idx,
                 bus.RegWrite & bus.MemWrite);
      end
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    drive(v);
    @(negedge clk);
    check(idx);
  endtask

  // ---------------- test ----------------
  initial begin
    int n_stall;
    rst = 1'b1;
    bus.opcode = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;

    // rst op     fn     z mr  state ill
    add_v(1, 6'o00, 6'o00, 0, 0, 5'd0, 0);            // in reset: IDLE, all zero
    add_v(0, 6'o00, 6'o00, 0, 0, 5'd0, 0);            // release
    add_v(0, 6'b000000, 6'b100000, 0, 0, 5'd1, 0);    // FETCH stalled
    add_v(0, 6'b000000, 6'b100000, 0, 0, 5'd1, 0);
    add_v(0, 6'b000000, 6'b100000, 0, 1, 5'd1, 0);    // add: fetch completes
    add_v(0, 6'b000000, 6'b100000, 0, 1, 5'd2, 0);
    add_v(0, 6'b000000, 6'b100000, 0, 1, 5'd7, 0);    // RTYPE_EX (mr ignored)
    add_v(0, 6'b000000, 6'b100000, 0, 1, 5'd8, 0);    // RTYPE_WB
    add_v(0, 6'b100011, 6'b000000, 0, 1, 5'd1, 0);    // lw
    add_v(0, 6'b100011, 6'b000000, 0, 1, 5'd2, 0);
    add_v(0, 6'b100011, 6'b000000, 0, 1, 5'd3, 0);
    add_v(0, 6'b100011, 6'b000000, 0, 0, 5'd4, 0);    // MEMRD held 4 cycles
    add_v(0, 6'b100011, 6'b000000, 0, 0, 5'd4, 0);
    add_v(0, 6'b100011, 6'b000000, 0, 0, 5'd4, 0);
    add_v(0, 6'b100011, 6'b000000, 0, 1, 5'd4, 0);
    add_v(0, 6'b100011, 6'b000000, 0, 1, 5'd5, 0);    // MEMWB
    add_v(0, 6'b000100, 6'b000000, 1, 1, 5'd1, 0);    // beq zero=1
    add_v(0, 6'b000100, 6'b000000, 1, 1, 5'd2, 0);
    add_v(0, 6'b000100, 6'b000000, 1, 1, 5'd12, 0);
    add_v(0, 6'b001101, 6'b000000, 0, 1, 5'd1, 0);    // ori
    add_v(0, 6'b001101, 6'b000000, 0, 1, 5'd2, 0);
    add_v(0, 6'b001101, 6'b000000, 0, 1, 5'd10, 0);
    add_v(0, 6'b001101, 6'b000000, 0, 1, 5'd11, 0);
    add_v(0, 6'b000000, 6'b001000, 0, 1, 5'd1, 0);    // jr
    add_v(0, 6'b000000, 6'b001000, 0, 1, 5'd2, 0);
    add_v(0, 6'b000000, 6'b001000, 0, 1, 5'd15, 0);
    add_v(0, 6'b111111, 6'b000000, 0, 1, 5'd1, 0);    // illegal opcode
    add_v(0, 6'b111111, 6'b000000, 0, 1, 5'd2, 0);
    add_v(0, 6'b111111, 6'b000000, 0, 0, 5'd1, 1);    // pulse, no strobes
    add_v(0, 6'b001000, 6'b000000, 0, 1, 5'd1, 0);    // pulse gone; addi
    add_v(0, 6'b001000, 6'b000000, 0, 1, 5'd2, 0);
    add_v(0, 6'b001000, 6'b000000, 0, 1, 5'd9, 0);
    add_v(0, 6'b001000, 6'b000000, 0, 1, 5'd11, 0);
    add_v(0, 6'b000010, 6'b000000, 0, 1, 5'd1, 0);    // j
    add_v(0, 6'b000010, 6'b000000, 0, 1, 5'd2, 0);
    add_v(0, 6'b000010, 6'b000000, 0, 1, 5'd13, 0);
    add_v(0, 6'b000011, 6'b000000, 0, 1, 5'd1, 0);    // jal
    add_v(0, 6'b000011, 6'b000000, 0, 1, 5'd2, 0);
    add_v(0, 6'b000011, 6'b000000, 0, 1, 5'd14, 0);
    add_v(0, 6'b101011, 6'b000000, 0, 1, 5'd1, 0);    // sw, reset mid-MEMWR
    add_v(0, 6'b101011, 6'b000000, 0, 1, 5'd2, 0);
    add_v(0, 6'b101011, 6'b000000, 0, 1, 5'd3, 0);
    add_v(0, 6'b101011, 6'b000000, 0, 0, 5'd6, 0);
    add_v(0, 6'b101011, 6'b000000, 0, 0, 5'd6, 0);
    add_v(1, 6'b101011, 6'b000000, 0, 0, 5'd0, 0);    // MemWrite drops at once
    add_v(0, 6'b101011, 6'b000000, 0, 0, 5'd0, 0);
    add_v(0, 6'b101011, 6'b000000, 0, 0, 5'd1, 0);
    add_v(0, 6'b101011, 6'b000000, 0, 1, 5'd1, 0);    // sw completes
    add_v(0, 6'b101011, 6'b000000, 0, 1, 5'd2, 0);
    add_v(0, 6'b101011, 6'b000000, 0, 1, 5'd3, 0);
    add_v(0, 6'b101011, 6'b000000, 0, 1, 5'd6, 0);
    add_v(0, 6'b000000, 6'b000000, 0, 0, 5'd1, 0);

    foreach (vecs[i]) apply(vecs[i], i);

    // lw with random memory latency in MEMRD
    for (int k = 0; k < 4; k++) begin
      vec_t v;
      n_stall = $urandom_range(0, 5);
      v.rst = 0; v.op = 6'b100011; v.fn = 6'b000000; v.zero = 0; v.ill = 0;
      v.mr = 1; v.st = 5'd1; apply(v, 100 + k * 20);
      v.st = 5'd2; apply(v, 101 + k * 20);
      v.st = 5'd3; apply(v, 102 + k * 20);
      v.st = 5'd4;
      for (int s = 0; s < n_stall; s++) begin
        v.mr = 0; apply(v, 103 + k * 20 + s);
      end
      v.mr = 1; apply(v, 110 + k * 20);
      v.st = 5'd5; v.mr = $urandom_range(0, 1); apply(v, 111 + k * 20);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
